// File: rtl/cpu_pkg.sv
// Shared core-wide register-file constants and types.
package cpu_pkg;
   localparam int REG_ADDR_W = 4;
   localparam int REG_DATA_W = 32;
   localparam int REG_PC     = 15;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;
   typedef logic [REG_DATA_W-1:0] word_t;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: PC override, write bypass, stored-word mux and busy select.
module regfile_read_port
   import cpu_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W,
   parameter int BYPASS = 1,
   parameter int PC_IDX = REG_PC
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] stored,
   input  logic              pend_bit,
   input  logic [DATA_W-1:0] pc_plus8,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] data,
   output logic              busy
);
   localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

   logic pc_hit;
   logic byp_hit;

   assign pc_hit  = (addr == PC_A);
   assign byp_hit = (BYPASS != 0) && we && (wa == addr);

   // A bypassed value is the retiring result itself, so it is never busy.
   always_comb begin
      if (pc_hit) begin
         data = pc_plus8;
         busy = 1'b0;
      end else if (byp_hit) begin
         data = wd;
         busy = 1'b0;
      end else begin
         data = stored;
         busy = pend_bit;
      end
   end
endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with one write port and a per-register pending scoreboard.
module register_file_mp
   import cpu_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W,
   parameter int NUM_RD = 3,
   parameter int BYPASS = 1,
   parameter int PC_IDX = REG_PC
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [DATA_W-1:0]        pc_plus8,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        wa,
   input  logic [DATA_W-1:0]        wd,
   input  logic                     iss_valid,
   input  logic [ADDR_W-1:0]        iss_addr,
   input  logic                     flush,
   output logic [2**ADDR_W-1:0]     pending
);
   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  pend_q;
   logic [DEPTH-1:0]  pend_d;
   logic              wr_ok;
   logic              iss_ok;

   assign wr_ok  = we && (wa != PC_A);
   assign iss_ok = iss_valid && (iss_addr != PC_A);

   // Set is applied after clear so a new producer supersedes the retiring one.
   always_comb begin
      // NOTE: start from the held value so every path assigns pend_d and no latch is inferred.
      pend_d = pend_q;
      if (flush) begin
         pend_d = '0;
      end else begin
         if (wr_ok)  pend_d[wa]       = 1'b0;
         if (iss_ok) pend_d[iss_addr] = 1'b1;
      end
      pend_d[PC_A] = 1'b0;
   end

   // NOTE: the storage array is flop-based and reset word by word, which a RAM macro could not do asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
      end else begin
         // NOTE: non-blocking updates so every state element samples pre-edge values.
         pend_q <= pend_d;
         if (wr_ok) mem[wa] <= wd;
      end
   end

   assign pending = pend_q;

   for (genvar i = 0; i < NUM_RD; i++) begin : g_port
      regfile_read_port #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .BYPASS (BYPASS),
         .PC_IDX (PC_IDX)
      ) u_port (
         .addr     (rd_addr[i*ADDR_W +: ADDR_W]),
         .stored   (mem[rd_addr[i*ADDR_W +: ADDR_W]]),
         .pend_bit (pend_q[rd_addr[i*ADDR_W +: ADDR_W]]),
         .pc_plus8 (pc_plus8),
         .we       (we),
         .wa       (wa),
         .wd       (wd),
         .data     (rd_data[i*DATA_W +: DATA_W]),
         .busy     (rd_busy[i])
      );
   end
endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a bypassing and a non-bypassing instance share stimulus and one reference model.
module tb_register_file_mp;
   import cpu_pkg::*;

   localparam int NRD = 3;
   localparam int AW  = 4;
   localparam int DW  = 32;
   localparam int PCI = 15;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NRD*AW-1:0] rd_addr;
   logic [DW-1:0]     pc_plus8;
   logic              we;
   logic [AW-1:0]     wa;
   logic [DW-1:0]     wd;
   logic              iss_valid;
   logic [AW-1:0]     iss_addr;
   logic              flush;
   logic [NRD*DW-1:0] rd_data_b, rd_data_n;
   logic [NRD-1:0]    rd_busy_b, rd_busy_n;
   logic [15:0]       pending_b, pending_n;

   always #5 clk = ~clk;

   register_file_mp #(.NUM_RD(NRD), .BYPASS(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .pc_plus8(pc_plus8), .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid),
      .iss_addr(iss_addr), .flush(flush), .pending(pending_b));

   register_file_mp #(.NUM_RD(NRD), .BYPASS(0)) dut_n (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
      .pc_plus8(pc_plus8), .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid),
      .iss_addr(iss_addr), .flush(flush), .pending(pending_n));

   // Reference model: architectural register contents and outstanding-result set.
   logic [DW-1:0] model_mem [16];
   logic [15:0]   model_pend;
   int total = 0;
   int bad   = 0;

   typedef struct {
      logic          we;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic          iss;
      logic [AW-1:0] ia;
      logic          flush;
      logic [AW-1:0] ra0;
      logic [DW-1:0] exp_d0;
      logic          exp_b0;
      logic [15:0]   exp_pend;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] exp_data(input int p, input bit byp);
      logic [AW-1:0] a;
      a = rd_addr[p*AW +: AW];
      if (a == AW'(PCI)) return pc_plus8;
      if (byp && we && wa == a) return wd;
      return model_mem[a];
   endfunction

   function automatic logic exp_busy(input int p, input bit byp);
      logic [AW-1:0] a;
      a = rd_addr[p*AW +: AW];
      if (a == AW'(PCI)) return 1'b0;
      if (byp && we && wa == a) return 1'b0;
      return model_pend[a];
   endfunction

   task automatic check_model();
      for (int p = 0; p < NRD; p++) begin
         check($sformatf("rd_data_b[%0d]", p), 64'(rd_data_b[p*DW +: DW]), 64'(exp_data(p, 1'b1)));
         check($sformatf("rd_busy_b[%0d]", p), 64'(rd_busy_b[p]), 64'(exp_busy(p, 1'b1)));
         check($sformatf("rd_data_n[%0d]", p), 64'(rd_data_n[p*DW +: DW]), 64'(exp_data(p, 1'b0)));
         check($sformatf("rd_busy_n[%0d]", p), 64'(rd_busy_n[p]), 64'(exp_busy(p, 1'b0)));
      end
      check("pending_b", 64'(pending_b), 64'(model_pend));
      check("pending_n", 64'(pending_n), 64'(model_pend));
   endtask

   task automatic model_clear();
      for (int r = 0; r < 16; r++) model_mem[r] = '0;
      model_pend = '0;
   endtask

   // Advance one clock edge, applying the architectural rules to the model; returns at posedge+1.
   task automatic edge_step();
      @(posedge clk);
      if (rst_n) begin
         if (we && wa != AW'(PCI)) model_mem[wa] = wd;
         if (flush) model_pend = '0;
         else begin
            if (we && wa != AW'(PCI)) model_pend[wa] = 1'b0;
            if (iss_valid && iss_addr != AW'(PCI)) model_pend[iss_addr] = 1'b1;
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      we = 1'b0; wa = '0; wd = '0; iss_valid = 1'b0; iss_addr = '0; flush = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{1, 5,  32'hDEAD_BEEF, 0, 0, 0, 5,  32'hDEAD_BEEF, 0, 16'h0000};
      vecs[1]  = '{0, 0,  32'h0,         0, 0, 0, 5,  32'hDEAD_BEEF, 0, 16'h0000};
      vecs[2]  = '{1, 15, 32'h1234,      0, 0, 0, 15, 32'h0000_0108, 0, 16'h0000};
      vecs[3]  = '{0, 0,  32'h0,         1, 7, 0, 7,  32'h0,         0, 16'h0000};
      vecs[4]  = '{0, 0,  32'h0,         0, 0, 0, 7,  32'h0,         1, 16'h0080};
      vecs[5]  = '{1, 7,  32'h77,        0, 0, 0, 7,  32'h77,        0, 16'h0080};
      vecs[6]  = '{0, 0,  32'h0,         0, 0, 0, 7,  32'h77,        0, 16'h0000};
      vecs[7]  = '{1, 7,  32'h88,        1, 7, 0, 7,  32'h88,        0, 16'h0000};
      vecs[8]  = '{0, 0,  32'h0,         0, 0, 0, 7,  32'h88,        1, 16'h0080};
      vecs[9]  = '{0, 0,  32'h0,         1, 1, 0, 0,  32'h0,         0, 16'h0080};
      vecs[10] = '{0, 0,  32'h0,         1, 4, 0, 4,  32'h0,         0, 16'h0082};
      vecs[11] = '{0, 0,  32'h0,         1, 9, 1, 4,  32'h0,         1, 16'h0092};
      vecs[12] = '{0, 0,  32'h0,         0, 0, 0, 4,  32'h0,         0, 16'h0000};

      // Reset then read.
      model_clear();
      idle_inputs();
      rst_n    = 1'b0;
      pc_plus8 = 32'h0000_0108;
      rd_addr  = {4'd15, 4'd0, 4'd3};
      #2;
      check("reset rd_data[0]", 64'(rd_data_b[0 +: DW]), 64'h0);
      check("reset rd_data[1]", 64'(rd_data_b[DW +: DW]), 64'h0);
      check("reset rd_data[2]", 64'(rd_data_b[2*DW +: DW]), 64'h108);
      check("reset rd_busy", 64'(rd_busy_b), 64'h0);
      check("reset pending", 64'(pending_b), 64'h0);
      check_model();
      edge_step();
      edge_step();
      rst_n = 1'b1;

      // Directed table: write/read-back, PC drop, scoreboard lifecycle, flush priority.
      for (int k = 0; k < 13; k++) begin
         we = vecs[k].we; wa = vecs[k].wa; wd = vecs[k].wd;
         iss_valid = vecs[k].iss; iss_addr = vecs[k].ia; flush = vecs[k].flush;
         rd_addr = {4'd15, 4'd0, vecs[k].ra0};
         #1;
         check($sformatf("vec%0d d0", k), 64'(rd_data_b[0 +: DW]), 64'(vecs[k].exp_d0));
         check($sformatf("vec%0d b0", k), 64'(rd_busy_b[0]), 64'(vecs[k].exp_b0));
         check($sformatf("vec%0d pend", k), 64'(pending_b), 64'(vecs[k].exp_pend));
         check_model();
         edge_step();
      end

      // Same-cycle bypass: bypassing instance sees wd, the other the old value.
      idle_inputs();
      we = 1'b1; wa = 4'd2; wd = 32'hCAFE_0001;
      rd_addr = {4'd15, 4'd2, 4'd5};
      #1;
      check("bypass data b", 64'(rd_data_b[DW +: DW]), 64'hCAFE_0001);
      check("bypass busy b", 64'(rd_busy_b[1]), 64'h0);
      check("bypass data n", 64'(rd_data_n[DW +: DW]), 64'h0);
      check_model();
      edge_step();

      // Asynchronous reset between clock edges.
      idle_inputs();
      we = 1'b1; wa = 4'd3; wd = 32'h55;
      edge_step();
      idle_inputs();
      iss_valid = 1'b1; iss_addr = 4'd3;
      edge_step();
      idle_inputs();
      rd_addr = {4'd15, 4'd3, 4'd3};
      #1;
      check("pre-reset mem3", 64'(rd_data_n[0 +: DW]), 64'h55);
      check("pre-reset pend", 64'(pending_b), 64'h0008);
      #1;
      rst_n = 1'b0;
      model_clear();
      #1;
      check("async mem3", 64'(rd_data_b[0 +: DW]), 64'h0);
      check("async pend b", 64'(pending_b), 64'h0);
      check("async pend n", 64'(pending_n), 64'h0);
      check("async busy", 64'(rd_busy_b), 64'h0);
      we = 1'b1; wa = 4'd3; wd = 32'hAA; iss_valid = 1'b1; iss_addr = 4'd3;
      #1;
      check("reset bypass b", 64'(rd_data_b[DW +: DW]), 64'hAA);
      check("reset bypass n", 64'(rd_data_n[DW +: DW]), 64'h0);
      check_model();
      edge_step();
      check_model();
      idle_inputs();
      rst_n = 1'b1;

      // Randomised traffic against the model.
      for (int c = 0; c < 400; c++) begin
         pc_plus8  = $urandom;
         we        = 1'($urandom_range(0, 1));
         wa        = AW'($urandom);
         wd        = $urandom;
         iss_valid = 1'($urandom_range(0, 1));
         iss_addr  = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
         flush     = ($urandom_range(0, 15) == 0);
         rd_addr   = {AW'($urandom), ($urandom_range(0, 1) == 0) ? wa : AW'($urandom), AW'($urandom)};
         #1;
         check_model();
         edge_step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
